mdu_iter: RTL and testbench

- Parametrised multiply/divide unit for the CPU EX stage; owns the HI/LO registers.
- Multiplies use a fixed-latency pipeline.
- Divides use a true radix-2 restoring iterative divider, one quotient bit per cycle.
- Adds multiply-accumulate ops (madd/maddu/msub/msubu) and a done strobe.

---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_iter_if.sv | 22 ++
 rtl/mdu_div_core.sv | 61 ++++++
 rtl/mdu_iter.sv | 158 +++++++++++++++
 tb/tb_mdu_iter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Op encodings, FSM states and op-class helpers for mdu_iter.
// Revision : 1.0
// ============================================================================
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MTHI  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) ||
           (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter_if
// Brief    : Issue/read bus between the EX stage and the multiply/divide unit.
// Revision : 1.0
// ============================================================================
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_sel;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, rd_sel, input out, busy, done);
  modport slave  (input start, op, a, b, rd_sel, output out, busy, done);
endinterface
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_core
// Brief    : Radix-2 restoring divider datapath on magnitudes, sign fix on fix.
// Revision : 1.0
// ============================================================================
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  logic [WIDTH-1:0] r_rem, r_quo, r_div;
  logic             r_qneg, r_rneg;

  logic             w_a_neg, w_b_neg, w_ge;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_sub;
  logic [WIDTH:0]   w_rem_sh;

  assign w_a_neg  = is_signed & a[WIDTH-1];
  assign w_b_neg  = is_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Partial remainder is always < divisor, so the W-bit difference is exact when w_ge.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_div};
  assign w_sub    = w_rem_sh[WIDTH-1:0] - r_div;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (load) begin
      r_rem  <= '0;
      r_quo  <= w_a_mag;
      r_div  <= w_b_mag;
      r_qneg <= w_a_neg ^ w_b_neg;
      r_rneg <= w_a_neg;
    end else if (step) begin
      r_rem  <= w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
      r_quo  <= {r_quo[WIDTH-2:0], w_ge};
    end
  end

  assign quo = (fix && r_qneg) ? -r_quo : r_quo;
  assign rem = (fix && r_rneg) ? -r_rem : r_rem;

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Multiply/divide unit owning HI/LO; fixed-latency mult, iterative div.
//            Optional exception flush input enabled by MDU_CANCEL_EN.
// Revision : 1.0
// ============================================================================
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int CNT_W       = 6
) (
  input  logic      clk,
  input  logic      reset,
`ifdef MDU_CANCEL_EN
  input  logic      cancel,
`endif
  mdu_iter_if.slave bus
);
  localparam logic [CNT_W-1:0] c_MUL_LAST = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(WIDTH);

  mdu_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [2*WIDTH-1:0] r_mul_acc;
  logic               r_busy, r_done;

  logic               w_cancel, w_sgn, w_div_load, w_div_step, w_div_fix;
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod, w_hilo, w_mul_acc;
  logic [WIDTH-1:0]   w_quo, w_rem;

`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  // Full product and accumulate are resolved at launch; MUL only models latency.
  assign w_sgn   = is_signed_op(bus.op);
  assign w_ext_a = w_sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign w_ext_b = w_sgn ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign w_prod  = w_ext_a * w_ext_b;
  assign w_hilo  = {r_hi, r_lo};

  always_comb begin
    w_mul_acc = w_prod;
    case (bus.op)
      MDU_MADD, MDU_MADDU: w_mul_acc = w_hilo + w_prod;
      MDU_MSUB, MDU_MSUBU: w_mul_acc = w_hilo - w_prod;
      default:             w_mul_acc = w_prod;
    endcase
  end

  assign w_div_load = (r_state == ST_IDLE) && bus.start && !w_cancel &&
                      is_div_op(bus.op) && (bus.b != '0);
  assign w_div_step = (r_state == ST_DIV) && !w_cancel;
  assign w_div_fix  = (r_state == ST_FIX);

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      (w_div_load),
    .step      (w_div_step),
    .fix       (w_div_fix),
    .is_signed (w_sgn),
    .a         (bus.a),
    .b         (bus.b),
    .quo       (w_quo),
    .rem       (w_rem)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mul_acc <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !w_cancel) begin
            if (bus.op == MDU_MTLO) begin
              r_lo <= bus.a;
            end else if (bus.op == MDU_MTHI) begin
              r_hi <= bus.a;
            end else if (is_mul_op(bus.op)) begin
              r_mul_acc <= w_mul_acc;
              r_state   <= ST_MUL;
              r_busy    <= 1'b1;
              r_cnt     <= CNT_W'(1);
            end else if (is_div_op(bus.op)) begin
              if (bus.b != '0) begin
                r_state <= ST_DIV;
                r_busy  <= 1'b1;
                r_cnt   <= CNT_W'(1);
              end else begin
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_MUL: begin
          if (w_cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == c_MUL_LAST) begin
            {r_hi, r_lo} <= r_mul_acc;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (w_cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == c_DIV_LAST) begin
            r_state <= ST_FIX;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!w_cancel) begin
            r_lo   <= w_quo;
            r_hi   <= w_rem;
            r_done <= 1'b1;
          end
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = bus.rd_sel ? r_hi : r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Directed self-checking bench for mdu_iter.
// Revision : 1.0
// ============================================================================
module tb_mdu_iter;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
`ifdef MDU_CANCEL_EN
  logic cancel;
`endif

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32), .MULT_CYCLES(5), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef MDU_CANCEL_EN
    .cancel (cancel),
`endif
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic launch(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    tick();
    bus.start = 1'b0;
    bus.op    = MDU_NONE;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic get_hilo(output logic [63:0] v);
    bus.rd_sel = 1'b1;
    #1 v[63:32] = bus.out;
    bus.rd_sel = 1'b0;
    #1 v[31:0] = bus.out;
  endtask

  logic [63:0] hl;
  int          n;
  logic        seen;

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.op = MDU_NONE;
    bus.a = '0;
    bus.b = '0;
    bus.rd_sel = 1'b0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset clears HI/LO
    launch(MDU_MTHI, 32'h1234, 0);
    get_hilo(hl);
    chk("mthi", hl, 64'h00001234_00000000);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    get_hilo(hl);
    chk("reset_hilo", hl, 64'h0);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    chk("reset_done", 64'(bus.done), 64'h0);
    tick();

    // Undefined op does nothing
    launch(4'd11, 32'h5, 32'h6);
    chk("op11_busy", 64'(bus.busy), 64'h0);
    chk("op11_done", 64'(bus.done), 64'h0);

    // Signed and unsigned multiply
    launch(MDU_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_busy_on", 64'(bus.busy), 64'h1);
    get_hilo(hl);
    chk("mult_no_partial", hl, 64'h0);
    wait_done(n);
    chk("mult_cycles", 64'(n), 64'd5);
    chk("mult_done", 64'(bus.done), 64'h1);
    get_hilo(hl);
    chk("mult_res", hl, 64'hFFFFFFFF_FFFFFFFA);
    launch(MDU_MULTU, 32'hFFFFFFFE, 32'd3);
    chk("mult_done_pulse", 64'(bus.done), 64'h0);
    wait_done(n);
    get_hilo(hl);
    chk("multu_res", hl, 64'h00000002_FFFFFFFA);

    // Divides, launched on the done cycle of the previous op
    launch(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    chk("div_cycles", 64'(n), 64'd33);
    chk("div_done", 64'(bus.done), 64'h1);
    get_hilo(hl);
    chk("div_res", hl, 64'hFFFFFFFF_FFFFFFFD);
    launch(MDU_DIVU, 32'd7, 32'd2);
    wait_done(n);
    get_hilo(hl);
    chk("divu_res", hl, 64'h00000001_00000003);
    launch(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    get_hilo(hl);
    chk("div_ovf", hl, 64'h00000000_80000000);
    launch(MDU_DIV, 32'd100, 32'hFFFFFFF9);
    wait_done(n);
    get_hilo(hl);
    chk("div_pos_neg", hl, 64'h00000002_FFFFFFF2);

    // Multiply-accumulate
    launch(MDU_MTHI, 32'd0, 0);
    launch(MDU_MTLO, 32'd10, 0);
    launch(MDU_MADD, 32'd4, 32'd5);
    wait_done(n);
    get_hilo(hl);
    chk("madd_res", hl, 64'h00000000_0000001E);
    launch(MDU_MSUBU, 32'd1, 32'd32);
    wait_done(n);
    get_hilo(hl);
    chk("msubu_res", hl, 64'hFFFFFFFF_FFFFFFFE);
    launch(MDU_MSUB, 32'hFFFFFFFF, 32'd2);
    wait_done(n);
    get_hilo(hl);
    chk("msub_res", hl, 64'h0);
    launch(MDU_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    get_hilo(hl);
    chk("maddu_res", hl, 64'hFFFFFFFE_00000001);

    // Divide by zero: done only, HI/LO untouched
    launch(MDU_MTLO, 32'h55, 0);
    launch(MDU_DIV, 32'd9, 32'd0);
    chk("dz_done", 64'(bus.done), 64'h1);
    chk("dz_busy", 64'(bus.busy), 64'h0);
    tick();
    chk("dz_done_pulse", 64'(bus.done), 64'h0);
    get_hilo(hl);
    chk("dz_hilo", hl, 64'hFFFFFFFE_00000055);

    // mtlo while busy is ignored and partial results stay hidden
    launch(MDU_DIVU, 32'd100, 32'd7);
    tick(); tick();
    launch(MDU_MTLO, 32'h99, 0);
    get_hilo(hl);
    chk("busy_mtlo_ignored", hl, 64'hFFFFFFFE_00000055);
    wait_done(n);
    get_hilo(hl);
    chk("busy_div_res", hl, 64'h00000002_0000000E);

    // Reset mid-divide
    launch(MDU_DIV, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_mid_busy", 64'(bus.busy), 64'h0);
    get_hilo(hl);
    chk("rst_mid_hilo", hl, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | bus.done;
      tick();
    end
    chk("rst_mid_no_done", 64'(seen), 64'h0);

`ifdef MDU_CANCEL_EN
    launch(MDU_MTLO, 32'h77, 0);
    launch(MDU_DIV, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 64'(bus.busy), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | bus.done;
      tick();
    end
    chk("cancel_no_done", 64'(seen), 64'h0);
    get_hilo(hl);
    chk("cancel_hilo", hl, 64'h00000000_00000077);
    cancel = 1'b1;
    launch(MDU_MTLO, 32'h11, 0);
    cancel = 1'b0;
    get_hilo(hl);
    chk("cancel_mt", hl, 64'h00000000_00000077);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
